// File: rtl/io_input_handshake.sv
// Serves the CPU IN instruction: once a request is pending, the next fresh button
// press captures the switch bank and returns it with a one-cycle acknowledge.
module io_input_handshake #(
  parameter int SW_W   = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_db,
  input  logic [SW_W-1:0]   sw_in,
  input  logic              in_req,
  output logic              in_ack,
  output logic [DATA_W-1:0] in_data,
  output logic              waiting,
  output logic              btn_pulse,
  output logic [CNT_W-1:0]  in_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                btn_prev_q;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                waiting_q;
  logic                pulse_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                edge_det;

  assign edge_det = btn_db & ~btn_prev_q;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        // A press coinciding with the request is deliberately not a capture.
        if (in_req) state_d = ARMED;
      end
      ARMED: begin
        if (!in_req) begin
          state_d = IDLE;
        end else if (edge_det) begin
          data_d  = DATA_W'(sw_in);
          ack_d   = 1'b1;
          count_d = count_q + 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!in_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // waiting is derived from the next state so it lines up with state==ARMED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      btn_prev_q <= 1'b1;
      ack_q      <= 1'b0;
      data_q     <= '0;
      waiting_q  <= 1'b0;
      pulse_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_db;
      ack_q      <= ack_d;
      data_q     <= data_d;
      waiting_q  <= (state_d == ARMED);
      pulse_q    <= edge_det;
      count_q    <= count_d;
    end
  end

  assign in_ack    = ack_q;
  assign in_data   = data_q;
  assign waiting   = waiting_q;
  assign btn_pulse = pulse_q;
  assign in_count  = count_q;

endmodule
